// File: rtl/mem_rmw_pkg.sv
// mem_rmw_pkg: shared types and helpers for the banked RMW memory
package mem_rmw_pkg;
  localparam int MAXW = 512;
  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} wr_state_e;
  function automatic logic [MAXW-1:0] lane_merge(input logic [MAXW-1:0] old_w, input logic [MAXW-1:0] new_w,
                                                 input logic [MAXW-1:0] mask, input int gran);
    for (int i = 0; i < MAXW; i++) lane_merge[i] = mask[i/gran] ? new_w[i] : old_w[i];
  endfunction
  function automatic int num_banks(input int depth, input int bank_depth);
    return (depth + bank_depth - 1) / bank_depth;
  endfunction
endpackage

// File: rtl/mem_rf_bank.sv
// mem_rf_bank: behavioural 1R1W synchronous-read register-file macro, ARM port map
module mem_rf_bank #(
  parameter int WORDS = 32,
  parameter int BITS = 64,
  parameter int AW = 5
)(
  input  logic            CLKA,
  input  logic            CENA,
  input  logic [AW-1:0]   AA,
  output logic [BITS-1:0] QA,
  input  logic            CLKB,
  input  logic            CENB,
  input  logic [AW-1:0]   AB,
  input  logic [BITS-1:0] DB
);
  logic [BITS-1:0] mem [WORDS];
  always_ff @(posedge CLKA) if (!CENA) QA <= mem[AA];
  always_ff @(posedge CLKB) if (!CENB) mem[AB] <= DB;
endmodule

// File: rtl/mem_1r1w_rmw_banked.sv
// mem_1r1w_rmw_banked: masked 1R1W memory on mask-less banked macros via RMW and forwarding
module mem_1r1w_rmw_banked import mem_rmw_pkg::*; #(
  parameter int DEPTH = 48,
  parameter int WIDTH = 64,
  parameter int MASK_GRAN = 8,
  parameter int BANK_DEPTH = 32,
  parameter int AW = $clog2(DEPTH)
)(
  input  logic                       R0_clk,
  input  logic                       rst_n,
  input  logic [AW-1:0]              R0_addr,
  input  logic                       R0_en,
  output logic                       R0_ready,
  output logic                       R0_valid,
  output logic [WIDTH-1:0]           R0_data,
  input  logic [AW-1:0]              W0_addr,
  input  logic                       W0_en,
  output logic                       W0_ready,
  input  logic [WIDTH-1:0]           W0_data,
  input  logic [WIDTH/MASK_GRAN-1:0] W0_mask
);
  localparam int ML = WIDTH / MASK_GRAN;
  localparam int NBANKS = num_banks(DEPTH, BANK_DEPTH);
  localparam int RW = $clog2(BANK_DEPTH);
  localparam int BW = NBANKS > 1 ? $clog2(NBANKS) : 1;
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);
  wr_state_e state;
  logic [AW-1:0] lat_addr, c_addr, a_addr;
  logic [WIDTH-1:0] lat_data, c_data, merged, fwd_data;
  logic [ML-1:0] lat_mask;
  logic [BW-1:0] lat_bank, r_bank;
  logic r_fwd, r_oor, rd_acc, wr_acc, r_in, w_in, full, commit;
  logic [WIDTH-1:0] qa [NBANKS];
  logic [NBANKS-1:0] cena, cenb;
  assign R0_ready = state != RMW_RD;
  assign W0_ready = state == IDLE;
  assign rd_acc = R0_en && R0_ready;
  assign wr_acc = W0_en && W0_ready;
  assign r_in = {1'b0, R0_addr} < LIMIT;
  assign w_in = {1'b0, W0_addr} < LIMIT;
  assign full = &W0_mask;
  assign lat_bank = BW'(lat_addr >> RW);
  assign merged = WIDTH'(lane_merge(MAXW'(qa[lat_bank]), MAXW'(lat_data), MAXW'(lat_mask), MASK_GRAN));
  assign commit = (state == RMW_WR) || (wr_acc && w_in && full);
  assign c_addr = state == RMW_WR ? lat_addr : W0_addr;
  assign c_data = state == RMW_WR ? merged : W0_data;
  // the macro read port is borrowed for the old word while in RMW_RD
  assign a_addr = state == RMW_RD ? lat_addr : R0_addr;
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    assign cena[b] = !((state == RMW_RD || (rd_acc && r_in)) && BW'(a_addr >> RW) == BW'(b));
    assign cenb[b] = !(commit && BW'(c_addr >> RW) == BW'(b));
    mem_rf_bank #(.WORDS(BANK_DEPTH), .BITS(WIDTH), .AW(RW)) u_bank (
      .CLKA(R0_clk), .CENA(cena[b]), .AA(a_addr[RW-1:0]), .QA(qa[b]),
      .CLKB(R0_clk), .CENB(cenb[b]), .AB(c_addr[RW-1:0]), .DB(c_data)
    );
  end
  always_ff @(posedge R0_clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      lat_addr <= '0;
      lat_data <= '0;
      lat_mask <= '0;
      R0_valid <= 1'b0;
      r_fwd <= 1'b0;
      r_oor <= 1'b0;
      r_bank <= '0;
      fwd_data <= '0;
    end else begin
      state <= state == RMW_RD ? RMW_WR : state == RMW_WR ? IDLE :
               (wr_acc && w_in && |W0_mask && !full) ? RMW_RD : IDLE;
      if (wr_acc) begin
        lat_addr <= W0_addr;
        lat_data <= W0_data;
        lat_mask <= W0_mask;
      end
      R0_valid <= rd_acc;
      if (rd_acc) begin
        r_oor <= !r_in;
        r_bank <= BW'(R0_addr >> RW);
        r_fwd <= commit && c_addr == R0_addr;
        fwd_data <= c_data;
      end
    end
  assign R0_data = (!R0_valid || r_oor) ? '0 : r_fwd ? fwd_data : qa[r_bank];
endmodule

// File: doc/mem_1r1w_rmw_banked.md
# mem_1r1w_rmw_banked

Parametrised single-clock 1R1W memory built from fixed-size, non-maskable two-port register-file bank macros. The number of banks follows from `DEPTH`, and banks are selected by the upper address bits. Byte-granular write masks are emulated by an internal read-modify-write (RMW) sequence. Read-after-write hazards are handled by forwarding, so the macros themselves need no per-byte mask support. It sits between generated memory wrappers and the ARM RF macros wherever a masked memory maps onto mask-less macros.

## Interface
- `DEPTH`, 48: number of logical words.
- `WIDTH`, 64: word width in bits.
- `MASK_GRAN`, 8: bits per mask lane. `WIDTH % MASK_GRAN == 0`.
- `BANK_DEPTH`, 32: words per macro, a power of two. `NBANKS = ceil(DEPTH/BANK_DEPTH)`.
- `AW`, `$clog2(DEPTH)`: address width (derived).
- `clk`  in  1  single clock for both ports.
- `rst_n`  in  1  asynchronous, active-low reset.
- `R0_addr`  in  AW  read address.
- `R0_en`  in  1  read request.
- `R0_ready`  out  1  read port can accept a request this cycle.
- `R0_valid`  out  1  `R0_data` carries the result of the read accepted in the previous cycle.
- `R0_data`  out  WIDTH  read data. Zero when `R0_valid` is low.
- `W0_addr`  in  AW  write address.
- `W0_en`  in  1  write request.
- `W0_ready`  out  1  write port can accept a request this cycle.
- `W0_data`  in  WIDTH  write data.
- `W0_mask`  in  WIDTH/MASK_GRAN  lane enables. Bit i enables bits `[i*MASK_GRAN +: MASK_GRAN]`.

## Operation
- **Handshake.** A request is accepted when `en && ready` are high at a rising edge. Callers hold their request until it is accepted.
- **Bank select.** bank = `addr / BANK_DEPTH`, row = `addr % BANK_DEPTH`. Only the selected bank's chip enable is active.
- **Write FSM states:** IDLE, RMW_RD, RMW_WR.
- **IDLE**
  - `W0_ready=1`, `R0_ready=1`.
  - Accepted write with all mask bits set: commits to the macro this cycle; state stays IDLE.
  - Accepted write with mask == 0: dropped; stays IDLE.
  - Accepted write with a partial mask: latch addr/data/mask, go to RMW_RD.
- **RMW_RD**
  - Issues an internal read of the latched address on the macro read port.
  - `R0_ready=0`, `W0_ready=0`.
  - Go to RMW_WR.
- **RMW_WR**
  - Merge: new lanes where the mask is 1, old macro data where the mask is 0.
  - Commit the merged word to the write port.
  - `R0_ready=1`, `W0_ready=0`.
  - Go to IDLE.
- **Commit semantics.** A read sees every write committed in an earlier cycle or in the same cycle (write-first).
- **Forwarding.** A read whose address equals the address of a write committing in the same cycle returns the committed word, merged or full, through a one-entry forward register, not the macro output.
- **Out-of-range address** (`addr >= DEPTH`):
  - Write: accepted and dropped.
  - Read: accepted, returns zero with `R0_valid=1`.
- **Reset.** Memory contents are not reset. An RMW in progress at reset assertion is discarded.

## Timing
- **Read latency:** 1 cycle. `R0_valid` is high in the cycle after acceptance; the bank index and forward flag are registered at acceptance.
- **Write occupancy:** full-mask write 1 cycle (back-to-back allowed); partial write 3 cycles (accept, RMW_RD, RMW_WR), so peak throughput is 1 per 3 cycles.
- **Read blocking:** reads are blocked only in RMW_RD.
- **Reset values:**
  - state = IDLE
  - `R0_valid=0`, `R0_data=0`
  - `R0_ready=1`, `W0_ready=1` (combinational from state)
  - forward register = 0, bank-index register = 0
- **Simultaneous events:**
  - Read and full-mask write to the same address in the same IDLE cycle: the read returns the new data.
  - Read in RMW_WR to the pending address: returns the merged word.
  - Read in the acceptance cycle of a partial write to the same address: returns old data, because the write is not yet committed.

## Structure
- **Package `mem_rmw_pkg`:**
  - State enum (IDLE, RMW_RD, RMW_WR).
  - `function lane_merge(old, new, mask, gran)`.
  - `function num_banks(depth, bank_depth)`.
- **Sub-module `mem_rf_bank`:**
  - Behavioural 1R1W synchronous-read model of the macro, instantiated `NBANKS` times.
  - Active-low chip enables `CENA`/`CENB`.
  - Port map identical to the ARM macro so the model can be swapped for the hard macro at synthesis.
- **Top level:** FSM, merge datapath, forward register and output mux.

## Test plan
All scenarios use the defaults (DEPTH=48, WIDTH=64, gran 8, BANK_DEPTH=32).
1. Reset, then full-mask write `0x1122334455667788` to addr 40, then read 40 -> `R0_valid` one cycle later, data `0x1122334455667788`; bank 1 only enabled.
2. Write `0xFFFF...FF` to addr 5, then partial write data `0` with mask `0x0F` -> `W0_ready` low for 2 cycles; reading 5 afterwards gives `0xFFFFFFFF00000000`.
3. During a partial write: `R0_ready=0` in RMW_RD. A read of the same address in RMW_WR returns the merged word; a read of another address returns macro data.
4. Same-cycle full-mask write and read of addr 31 (bank 0, last row) -> new data forwarded. Repeat at addr 32 (bank 1, row 0).
5. Write and read at addr 50 (out of range) -> write dropped with no bank enabled; read returns 0 with `R0_valid=1`. Mask 0 -> contents unchanged.
6. Assert `rst_n` low during RMW_RD -> state IDLE, `R0_valid=0`, both readies 1 immediately; the target word is unchanged after reset.
